// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver for the pong game core.
// The raw PS/2 pins are synchronized and the clock is debounced. Each 11-bit
// frame (start, 8 data bits LSB first, odd parity, stop) is checked, and the
// frame's byte comes out as a one-cycle rx_valid pulse. A bad frame, or a
// partial frame that stalls, gives a one-cycle rx_err pulse instead.
// The make/break decoder turns the byte stream into level flags for the
// paddle-up key (W or up arrow) and the paddle-down key (S or down arrow).
//
// rx_valid / rx_err: both are single-cycle strobes with no back-pressure.
// rx_data is stable from an rx_valid pulse until the next rx_valid pulse.
// The two strobes are never high in the same cycle.
module ps2_key_rx #(
  parameter int          FILTER_LEN     = 8,
  parameter int          TIMEOUT_CYCLES = 65000,
  parameter logic [7:0]  KEY_UP         = 8'h1D,
  parameter logic [7:0]  KEY_DOWN       = 8'h1B,
  parameter logic [7:0]  EXT_UP         = 8'h75,
  parameter logic [7:0]  EXT_DOWN       = 8'h72
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       key_up_held,
  output logic       key_down_held
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] BREAK_CODE  = 8'hF0;
  localparam logic [7:0] EXTEND_CODE = 8'hE0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic          filt_prev_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          sample_evt;

  // Two-stage synchronizers. They reset to 1, the idle level of the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // The filtered clock flips only after FILTER_LEN samples in a row disagree with it.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d     = ~filt_q;
        filt_cnt_d = '0;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
  end

  // Filter state and the previous filtered level used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  // Sample event: a falling edge of the filtered PS/2 clock.
  assign sample_evt = filt_prev_q & ~filt_q;

  // ---------------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------------
  state_t        state_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          rx_err_q;
  logic          frame_ok;

  // Odd parity is over the data byte plus the parity bit. The stop bit must be 1.
  assign frame_ok = dat_s2_q & (^{shift_q, par_q});

  // Frame FSM: collects bits and drives the registered result strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tmo_q     <= '0;
          bit_cnt_q <= '0;
          if (sample_evt) begin
            if (!dat_s2_q) begin
              state_q   <= S_RECV;
              bit_cnt_q <= 4'd1;
            end else begin
              // A falling edge without a valid start bit is a framing error.
              rx_err_q <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (sample_evt) begin
            tmo_q     <= '0;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q <= 4'd8) begin
              shift_q <= {dat_s2_q, shift_q[7:1]};
            end else if (bit_cnt_q == 4'd9) begin
              par_q <= dat_s2_q;
            end else begin
              state_q   <= S_IDLE;
              bit_cnt_q <= '0;
              if (frame_ok) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end else begin
                rx_err_q <= 1'b1;
              end
            end
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // The keyboard stopped clocking mid-frame, so drop the partial byte.
            rx_err_q  <= 1'b1;
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            tmo_q     <= '0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;

  // ---------------------------------------------------------------------------
  // Make/break key decoder
  // ---------------------------------------------------------------------------
  logic brk_q, brk_d;
  logic ext_q, ext_d;
  logic up_a_q, up_a_d;
  logic up_b_q, up_b_d;
  logic down_a_q, down_a_d;
  logic down_b_q, down_b_d;
  logic up_held_q, down_held_q;

  // Resolve prefixes and key codes. A receive error drops any pending prefix.
  always_comb begin
    brk_d    = brk_q;
    ext_d    = ext_q;
    up_a_d   = up_a_q;
    up_b_d   = up_b_q;
    down_a_d = down_a_q;
    down_b_d = down_b_q;
    if (rx_err_q) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (rx_valid_q) begin
      if (rx_data_q == BREAK_CODE) begin
        brk_d = 1'b1;
      end else if (rx_data_q == EXTEND_CODE) begin
        ext_d = 1'b1;
      end else begin
        if (!ext_q) begin
          if (rx_data_q == KEY_UP)   up_a_d   = ~brk_q;
          if (rx_data_q == KEY_DOWN) down_a_d = ~brk_q;
        end else begin
          if (rx_data_q == EXT_UP)   up_b_d   = ~brk_q;
          if (rx_data_q == EXT_DOWN) down_b_d = ~brk_q;
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  // Decoder state. The held outputs are registered from the next-state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      up_a_q      <= 1'b0;
      up_b_q      <= 1'b0;
      down_a_q    <= 1'b0;
      down_b_q    <= 1'b0;
      up_held_q   <= 1'b0;
      down_held_q <= 1'b0;
    end else begin
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      up_a_q      <= up_a_d;
      up_b_q      <= up_b_d;
      down_a_q    <= down_a_d;
      down_b_q    <= down_b_d;
      up_held_q   <= up_a_d | up_b_d;
      down_held_q <= down_a_d | down_b_d;
    end
  end

  assign key_up_held   = up_held_q;
  assign key_down_held = down_held_q;

endmodule
